// File: rtl/adder64_seq.sv
// 64-bit add/subtract built from one time-shared 32-bit adder: low half, then high half.
// Latency 3 cycles from accept to done; start is ignored while busy, with no queuing.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    assign sum  = full[31:0];
    assign cout = full[32];
endmodule

module adder64_seq #(
    parameter int BORROW_OUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_sub,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        cout,
    output logic        overflow,
    output logic        zero,
    output logic        negative
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic BORROW_EN = (BORROW_OUT != 0);

    state_t      state;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        sub_q;
    logic        c_q;
    logic [31:0] lo_q;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    // The single adder sees the low half in LO and the high half in HI.
    always_comb begin
        add_a   = a_q[31:0];
        add_b   = b_q[31:0];
        add_cin = sub_q;
        if (state == HI) begin
            add_a   = a_q[63:32];
            add_b   = b_q[63:32];
            add_cin = c_q;
        end
    end

    adder32 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            lo_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1; the +1 enters as the low-half carry-in.
                        a_q   <= a;
                        b_q   <= op_sub ? ~b : b;
                        sub_q <= op_sub;
                        busy  <= 1'b1;
                        state <= LO;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                LO: begin
                    lo_q  <= add_sum;
                    c_q   <= add_cout;
                    state <= HI;
                end
                HI: begin
                    result   <= {add_sum, lo_q};
                    cout     <= add_cout ^ (sub_q & BORROW_EN);
                    overflow <= (a_q[63] == b_q[63]) & (add_sum[31] != a_q[63]);
                    zero     <= ({add_sum, lo_q} == 64'd0);
                    negative <= add_sum[31];
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder64_seq.sv
// Bench for adder64_seq: two instances (raw carry and borrow-out) share stimulus and are
// compared against a plain-arithmetic reference model.

module tb_adder64_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        busy0, done0, cout0, ovf0, zero0, neg0;
    logic        busy1, done1, cout1, ovf1, zero1, neg1;
    logic [63:0] result0, result1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    always #5 clk = ~clk;

    adder64_seq #(.BORROW_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy0), .done(done0), .result(result0), .cout(cout0),
        .overflow(ovf0), .zero(zero0), .negative(neg0)
    );

    adder64_seq #(.BORROW_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1),
        .overflow(ovf1), .zero(zero1), .negative(neg1)
    );

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic sub, input logic bo);
        exp_t        e;
        logic [64:0] wide;
        if (!sub) begin
            wide = {1'b0, x} + {1'b0, y};
            e.r  = wide[63:0];
            e.c  = wide[64];
            e.v  = (x[63] == y[63]) && (e.r[63] != x[63]);
        end else begin
            e.r = x - y;
            e.c = bo ? (x < y) : (x >= y);
            e.v = (x[63] != y[63]) && (e.r[63] != x[63]);
        end
        e.z = (e.r == 64'd0);
        e.n = e.r[63];
        return e;
    endfunction

    function automatic exp_t got0();
        return '{r: result0, c: cout0, v: ovf0, z: zero0, n: neg0};
    endfunction

    function automatic exp_t got1();
        return '{r: result1, c: cout1, v: ovf1, z: zero1, n: neg1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done; lat counts cycles after the accept edge.
    task automatic do_op(input logic [63:0] x, input logic [63:0] y, input logic sub,
                         output int lat, output int viol);
        viol   = 0;
        a      = x;
        b      = y;
        op_sub = sub;
        start  = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom();
        b     = {$urandom(), $urandom()};
        lat   = 1;
        while (!done0 && lat < 10) begin
            if (!busy0 || !busy1) viol++;
            tick();
            lat++;
        end
        if (!done0) lat = -1;
        if ((done0 && busy0) || (done1 && busy1) || (done0 != done1)) viol++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy0, done0, result0, cout0, ovf0, zero0, neg0} !== 70'd0 ||
            {busy1, done1, result1, cout1, ovf1, zero1, neg1} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: got r0=%h r1=%h busy=%b%b done=%b%b, want all 0",
                     result0, result1, busy0, busy1, done0, done1);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: cycle %0d busy=%b%b done=%b%b, want 0", i,
                         busy0, busy1, done0, done1);
            end
        end
    endtask

    task automatic check_op(input string name, input logic [63:0] x, input logic [63:0] y,
                            input logic sub);
        int   lat, viol;
        exp_t e0, e1;
        do_op(x, y, sub, lat, viol);
        e0 = model(x, y, sub, 1'b0);
        e1 = model(x, y, sub, 1'b1);
        checks++;
        if (lat !== 3 || viol !== 0) begin
            errors++;
            $display("FAIL %s_timing: latency=%0d violations=%0d, want latency 3 and 0", name, lat, viol);
        end
        checks++;
        if (got0() !== e0) begin
            errors++;
            $display("FAIL %s_bo0: got r=%h c=%b v=%b z=%b n=%b, want r=%h c=%b v=%b z=%b n=%b",
                     name, result0, cout0, ovf0, zero0, neg0, e0.r, e0.c, e0.v, e0.z, e0.n);
        end
        checks++;
        if (got1() !== e1) begin
            errors++;
            $display("FAIL %s_bo1: got r=%h c=%b v=%b z=%b n=%b, want r=%h c=%b v=%b z=%b n=%b",
                     name, result1, cout1, ovf1, zero1, neg1, e1.r, e1.c, e1.v, e1.z, e1.n);
        end
    endtask

    task automatic test_directed();
        check_op("cross_half", 64'h00000000_FFFFFFFF, 64'd1, 1'b0);
        checks++;
        if (result0 !== 64'h00000001_00000000 || cout0 !== 1'b0 || zero0 !== 1'b0) begin
            errors++;
            $display("FAIL cross_half_const: got %h c=%b z=%b, want 0000000100000000 c=0 z=0",
                     result0, cout0, zero0);
        end
        check_op("full_wrap", 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0);
        checks++;
        if (result0 !== 64'd0 || cout0 !== 1'b1 || zero0 !== 1'b1 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL full_wrap_const: got %h c=%b z=%b v=%b, want 0 c=1 z=1 v=0",
                     result0, cout0, zero0, ovf0);
        end
        check_op("signed_ovf", 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0);
        checks++;
        if (result0 !== 64'h80000000_00000000 || ovf0 !== 1'b1 || neg0 !== 1'b1) begin
            errors++;
            $display("FAIL signed_ovf_const: got %h v=%b n=%b, want 8000000000000000 v=1 n=1",
                     result0, ovf0, neg0);
        end
        check_op("sub_borrow", 64'd5, 64'd7, 1'b1);
        checks++;
        if (result0 !== 64'hFFFFFFFF_FFFFFFFE || cout0 !== 1'b0 || cout1 !== 1'b1 || neg0 !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow_const: got %h c0=%b c1=%b n=%b, want fffffffffffffffe c0=0 c1=1 n=1",
                     result0, cout0, cout1, neg0);
        end
        check_op("sub_equal", 64'h1234, 64'h1234, 1'b1);
        checks++;
        if (zero0 !== 1'b1 || cout0 !== 1'b1 || cout1 !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal_const: got z=%b c0=%b c1=%b, want z=1 c0=1 c1=0",
                     zero0, cout0, cout1);
        end
        check_op("sub_min", 64'h80000000_00000000, 64'd1, 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            if (i % 5 == 1) y[31:0] = ~x[31:0];
            if (i % 7 == 2) x = 64'h7FFFFFFF_FFFFFFFF;
            if (i % 9 == 3) y = x;
            check_op("random", x, y, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e3;
        int   lat;
        e1 = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        e3 = model(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b1, 1'b0);
        a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_2222_3333_4444; op_sub = 1'b0; start = 1'b1;
        tick();
        a = 64'hDEAD_BEEF_0000_0000; b = 64'h5; op_sub = 1'b1;      // LO: ignored
        tick();
        a = 64'h1; b = 64'hFFFF_FFFF_FFFF_FFFF; op_sub = 1'b0;     // HI: ignored
        tick();
        checks++;
        if (done0 !== 1'b1 || got0() !== e1) begin
            errors++;
            $display("FAIL busy_start_ignored: done=%b r=%h, want done=1 r=%h", done0, result0, e1.r);
        end
        a = 64'h10; b = 64'h20; op_sub = 1'b1;                     // DONE: accepted
        tick();
        start = 1'b0;
        a = '0; b = '0; op_sub = 1'b0;
        lat = 1;
        while (!done0 && lat < 10) begin
            checks++;
            if (got0() !== e1 || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL result_stable: cycle %0d r=%h busy=%b, want r=%h busy=1",
                         lat, result0, busy0, e1.r);
            end
            tick();
            lat++;
        end
        checks++;
        if (lat !== 3 || got0() !== e3) begin
            errors++;
            $display("FAIL back_to_back: latency=%0d r=%h, want latency 3 r=%h", lat, result0, e3.r);
        end
        tick();
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b after DONE, want 0 0", done0, busy0);
        end
    endtask

    task automatic test_abort();
        int seen;
        a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_1111_1111_1111; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();                                                      // now in HI
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy0, done0, result0, cout0, ovf0, zero0, neg0} !== 70'd0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b r=%h, want all 0", busy0, done0, result0);
        end
        tick();
        #3 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done0 || done1) seen++;
        end
        checks++;
        if (seen !== 0 || result0 !== 64'd0) begin
            errors++;
            $display("FAIL abort_no_done: done seen %0d times r=%h, want 0 and 0", seen, result0);
        end
        check_op("after_abort", 64'd3, 64'd4, 1'b0);
        checks++;
        if (result0 !== 64'd7) begin
            errors++;
            $display("FAIL after_abort_const: got %h, want 7", result0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder64_seq.md
Name: adder64_seq

Overview:
- Multi-cycle 64-bit add/subtract unit that time-shares one adder32 instance: lower half in one cycle, upper half in the next.
- The carry between halves is held in a register between the two cycles.
- Sits beside the single-cycle ALU as an area-reduced arithmetic path. Used for 64-bit address and accumulator updates that can tolerate 3-cycle latency.
- start/busy/done handshake; registered result and flags.

Parameters:
- BORROW_OUT, 0: when 1 and the op is a subtract, cout reports borrow (inverted carry). When 0, cout is the raw adder carry.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only when accepting (state IDLE or DONE)
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  64  operand A; sampled with start
- b  input  64  operand B; sampled with start
- busy  output  1  high in states LO and HI
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on
- result  output  64  registered sum/difference; holds until the next completion
- cout  output  1  carry out of bit 63 (see BORROW_OUT)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  result == 0
- negative  output  1  result[63]

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0, zero=0, negative=0; internal operand, op, carry and low-half registers cleared.
- Deassertion of rst is synchronised by the system reset tree; no local synchroniser.
- States: IDLE, LO, HI, DONE. Exactly one adder32 is instantiated; its inputs are muxed by state.
- Accept, at edge N, when state is IDLE or DONE and start=1:
  - latch a_q=a, b_q = op_sub ? ~b : b, sub_q=op_sub
  - state -> LO
- LO:
  - adder inputs a_q[31:0], b_q[31:0], cin=sub_q
  - edge N+1: lo_q <= sum, c_q <= cout; state -> HI
- HI:
  - adder inputs a_q[63:32], b_q[63:32], cin=c_q
  - edge N+2: result <= {sum, lo_q}; flags updated; state -> DONE
- Flags, computed at the HI edge:
  - cout = adder cout, XOR (sub_q & BORROW_OUT)
  - overflow = (a_q[63]==b_q[63]) & (sum[31]!=a_q[63])
  - zero = ({sum,lo_q}==0)
  - negative = sum[31]
- DONE:
  - done=1 for exactly this cycle
  - start=1 here is accepted (back-to-back, same latching rules) -> LO; otherwise -> IDLE
- Latency: done is high in the 3rd cycle after the accepting edge. Peak throughput is one op per 3 cycles.
- result and flags change only at the HI edge. They are never partially updated and stay stable while busy.
- start while busy (LO/HI): ignored. Operands are not re-latched, no queuing, no error.
- Input changes on a/b/op_sub after acceptance have no effect on the operation in flight.
- Wrap-around: 64-bit modular arithmetic; carry beyond bit 63 appears only on cout.
- Reset mid-operation (LO or HI): the operation is aborted, no done pulse, outputs return to reset values.
- done and busy are never high simultaneously.

Test Plan:
- Reset then idle: rst pulse with start=0 -> all outputs 0; busy stays 0 and no done for 10 cycles.
- Cross-half carry: a=0x00000000_FFFFFFFF, b=1, add -> done at cycle N+3, result=0x00000001_00000000, cout=0, overflow=0, zero=0.
- Full wrap: a=0xFFFFFFFF_FFFFFFFF, b=1, add -> result=0, cout=1, zero=1, overflow=0. Signed overflow: a=0x7FFFFFFF_FFFFFFFF, b=1 -> result=0x80000000_00000000, overflow=1, negative=1.
- Subtract with borrow: a=5, b=7, sub, BORROW_OUT=0 -> result=0xFFFFFFFF_FFFFFFFE, cout=0, negative=1. Same op with BORROW_OUT=1 -> cout=1. Case a=b=0x1234, sub -> zero=1, cout=1 (BORROW_OUT=0).
- Handshake: assert start during LO and HI with different operands -> ignored, first result unchanged. Assert start in the DONE cycle -> second op accepted, its done appears 3 cycles later.
- Abort: assert rst in HI -> no done pulse, result=0. After release, a fresh op (3+4) -> result=7.
